// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the D-cache and I-cache and routes tagged load returns to their owners.
// Optional feature macro ARB_ROUND_ROBIN_EN: alternate priority after each accept (default build: fixed D-cache priority).
`ifndef XLEN
`define XLEN 32
`endif

package mem_bus_pkg;
  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;
endpackage

module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_TAGS = 16,
  parameter int DATA_W   = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  BUS_COMMAND        d_command,
  input  logic [`XLEN-1:0]  d_addr,
  input  logic [DATA_W-1:0] d_data,
  output logic [3:0]        d_response,

  input  BUS_COMMAND        i_command,
  input  logic [`XLEN-1:0]  i_addr,
  output logic [3:0]        i_response,

  output logic [3:0]        d_ret_tag,
  output logic [3:0]        i_ret_tag,
  output logic [DATA_W-1:0] ret_data,

  output BUS_COMMAND        mem_command,
  output logic [`XLEN-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [3:0]        mem_response,
  input  logic [3:0]        mem_tag,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic [3:0]        d_outstanding,
  output logic [3:0]        i_outstanding,
  output logic              tag_err
);

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_D    = 2'd1,
    LOCK_I    = 2'd2
  } lock_t;

  localparam logic [4:0] TAG_LIMIT = 5'(NUM_TAGS);

  lock_t       lock;
  logic        prio_i;
  logic [15:0] own_valid;
  logic [15:0] own_i;
  logic [3:0]  d_cnt;
  logic [3:0]  i_cnt;
  logic        err;

  logic d_act;
  logic i_act;
  logic grant_d;
  logic grant_i;
  logic accept;
  logic acc_load;
  logic resp_ok;
  logic ret_ok;
  logic ret_hit;
  logic ret_miss;
  logic ret_own_i;
  logic d_inc;
  logic d_dec;
  logic i_inc;
  logic i_dec;

  // I-cache never stores, so a BUS_STORE from it is simply not a request.
  assign d_act = (d_command == BUS_LOAD) || (d_command == BUS_STORE);
  assign i_act = (i_command == BUS_LOAD);

  // A locked requester keeps the port while it still asks; otherwise single requester wins, priority breaks ties.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (!rst) begin
      if (lock == LOCK_D && d_act)           grant_d = 1'b1;
      else if (lock == LOCK_I && i_act)      grant_i = 1'b1;
      else if (d_act && (!i_act || !prio_i)) grant_d = 1'b1;
      else if (i_act)                        grant_i = 1'b1;
    end
  end

  always_comb begin
    mem_command = BUS_NONE;
    mem_addr    = '0;
    mem_data    = '0;
    if (grant_d) begin
      mem_command = d_command;
      mem_addr    = d_addr;
      mem_data    = d_data;
    end else if (grant_i) begin
      mem_command = BUS_LOAD;
      mem_addr    = i_addr;
    end
  end

  assign d_response = grant_d ? mem_response : 4'd0;
  assign i_response = grant_i ? mem_response : 4'd0;

  assign accept   = (grant_d || grant_i) && (mem_response != 4'd0);
  assign resp_ok  = ({1'b0, mem_response} < TAG_LIMIT);
  assign acc_load = accept && resp_ok && (mem_command == BUS_LOAD);

  // Returns are looked up in the table as it stood before this cycle's accept.
  assign ret_ok    = !rst && (mem_tag != 4'd0);
  assign ret_hit   = ret_ok && ({1'b0, mem_tag} < TAG_LIMIT) && own_valid[mem_tag];
  assign ret_miss  = ret_ok && !ret_hit;
  assign ret_own_i = own_i[mem_tag];

  assign d_ret_tag = (ret_hit && !ret_own_i) ? mem_tag : 4'd0;
  assign i_ret_tag = (ret_hit &&  ret_own_i) ? mem_tag : 4'd0;
  assign ret_data  = ret_hit ? mem_rdata : '0;

  assign d_inc = acc_load && grant_d;
  assign i_inc = acc_load && grant_i;
  assign d_dec = ret_hit && !ret_own_i;
  assign i_dec = ret_hit &&  ret_own_i;

  assign d_outstanding = d_cnt;
  assign i_outstanding = i_cnt;
  assign tag_err       = err;

  // Clearing the returned entry before writing the accepted one lets a tag be recycled in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_valid <= '0;
      own_i     <= '0;
      lock      <= LOCK_NONE;
      prio_i    <= 1'b0;
      d_cnt     <= 4'd0;
      i_cnt     <= 4'd0;
      err       <= 1'b0;
    end else begin
      if (ret_hit)
        own_valid[mem_tag] <= 1'b0;
      if (ret_miss)
        err <= 1'b1;
      if (acc_load) begin
        own_valid[mem_response] <= 1'b1;
        own_i[mem_response]     <= grant_i;
      end

      if (accept)       lock <= LOCK_NONE;
      else if (grant_d) lock <= LOCK_D;
      else if (grant_i) lock <= LOCK_I;
      else              lock <= LOCK_NONE;

`ifdef ARB_ROUND_ROBIN_EN
      if (accept)
        prio_i <= grant_d;
`else
      prio_i <= 1'b0;
`endif

      d_cnt <= d_cnt + {3'b000, d_inc} - {3'b000, d_dec};
      i_cnt <= i_cnt + {3'b000, i_inc} - {3'b000, i_dec};
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios plus randomized traffic checked every cycle against a tag-table model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int NT = 16;
  localparam int DW = 64;
  localparam int XW = `XLEN;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  BUS_COMMAND    d_command, i_command, mem_command;
  logic [XW-1:0] d_addr, i_addr, mem_addr;
  logic [DW-1:0] d_data, mem_data, ret_data, mem_rdata;
  logic [3:0]    d_response, i_response, d_ret_tag, i_ret_tag;
  logic [3:0]    mem_response, mem_tag, d_outstanding, i_outstanding;
  logic          tag_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: who owns each tag, per-requester counts, lock (0 none, 1 D, 2 I), priority (1 D, 2 I).
  bit m_valid [NT];
  bit m_own_i [NT];
  int m_dcnt, m_icnt, m_lock, m_prio;
  bit m_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NUM_TAGS(NT), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .d_command(d_command), .d_addr(d_addr), .d_data(d_data), .d_response(d_response),
    .i_command(i_command), .i_addr(i_addr), .i_response(i_response),
    .d_ret_tag(d_ret_tag), .i_ret_tag(i_ret_tag), .ret_data(ret_data),
    .mem_command(mem_command), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_response(mem_response), .mem_tag(mem_tag), .mem_rdata(mem_rdata),
    .d_outstanding(d_outstanding), .i_outstanding(i_outstanding), .tag_err(tag_err)
  );

  task automatic cmpVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int t = 0; t < NT; t++) begin
      m_valid[t] = 1'b0;
      m_own_i[t] = 1'b0;
    end
    m_dcnt = 0;
    m_icnt = 0;
    m_lock = 0;
    m_prio = 1;
    m_err  = 1'b0;
  endtask

  function automatic int grantOf();
    bit da = (d_command == BUS_LOAD) || (d_command == BUS_STORE);
    bit ia = (i_command == BUS_LOAD);
    if (m_lock == 1 && da) return 1;
    if (m_lock == 2 && ia) return 2;
    if (da && ia) return m_prio;
    if (da) return 1;
    if (ia) return 2;
    return 0;
  endfunction

  task automatic modelUpdate();
    int g = grantOf();
    if (mem_tag != 4'd0) begin
      if (m_valid[mem_tag]) begin
        m_valid[mem_tag] = 1'b0;
        if (m_own_i[mem_tag]) m_icnt--;
        else                  m_dcnt--;
      end else begin
        m_err = 1'b1;
      end
    end
    if (g != 0 && mem_response != 4'd0) begin
      if (g == 2 || d_command == BUS_LOAD) begin
        m_valid[mem_response] = 1'b1;
        m_own_i[mem_response] = (g == 2);
        if (g == 2) m_icnt++;
        else        m_dcnt++;
      end
      m_lock = 0;
      if (RR) m_prio = (g == 1) ? 2 : 1;
    end else begin
      m_lock = g;
    end
  endtask

  task automatic checkOutput();
    int            g;
    BUS_COMMAND    e_cmd = BUS_NONE;
    logic [XW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;
    logic [DW-1:0] e_rd = '0;
    logic [3:0]    e_dr = 4'd0, e_ir = 4'd0, e_drt = 4'd0, e_irt = 4'd0;
    if (!rst) begin
      g = grantOf();
      if (g == 1) begin
        e_cmd = d_command; e_addr = d_addr; e_data = d_data; e_dr = mem_response;
      end else if (g == 2) begin
        e_cmd = BUS_LOAD; e_addr = i_addr; e_ir = mem_response;
      end
      if (mem_tag != 4'd0 && m_valid[mem_tag]) begin
        e_rd = mem_rdata;
        if (m_own_i[mem_tag]) e_irt = mem_tag;
        else                  e_drt = mem_tag;
      end
    end
    cmpVal("mem_command", 64'(mem_command), 64'(e_cmd));
    cmpVal("mem_addr", 64'(mem_addr), 64'(e_addr));
    cmpVal("mem_data", 64'(mem_data), 64'(e_data));
    cmpVal("d_response", 64'(d_response), 64'(e_dr));
    cmpVal("i_response", 64'(i_response), 64'(e_ir));
    cmpVal("d_ret_tag", 64'(d_ret_tag), 64'(e_drt));
    cmpVal("i_ret_tag", 64'(i_ret_tag), 64'(e_irt));
    cmpVal("ret_data", 64'(ret_data), 64'(e_rd));
    cmpVal("d_outstanding", 64'(d_outstanding), 64'(m_dcnt));
    cmpVal("i_outstanding", 64'(i_outstanding), 64'(m_icnt));
    cmpVal("tag_err", 64'(tag_err), 64'(m_err));
  endtask

  task automatic applyStimulus(input logic r, input BUS_COMMAND dc, input logic [XW-1:0] da,
                               input logic [DW-1:0] dd, input BUS_COMMAND ic, input logic [XW-1:0] ia,
                               input logic [3:0] mr, input logic [3:0] mt, input logic [DW-1:0] md);
    @(negedge clk);
    rst = r;
    d_command = dc; d_addr = da; d_data = dd;
    i_command = ic; i_addr = ia;
    mem_response = mr; mem_tag = mt; mem_rdata = md;
    if (r) modelReset();
    #1;
    checkOutput();
  endtask

  task automatic finishCycle();
    @(posedge clk);
    if (rst) modelReset();
    else     modelUpdate();
  endtask

  task automatic idle(input logic [3:0] mt, input logic [DW-1:0] md);
    applyStimulus(1'b0, BUS_NONE, '0, '0, BUS_NONE, '0, 4'd0, mt, md);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, BUS_NONE, '0, '0, BUS_NONE, '0, 4'd0, 4'd0, '0);
    finishCycle();
  endtask

  task automatic randomCycle();
    BUS_COMMAND dc, ic;
    logic [3:0] mt, mr;
    int         g, r;
    int         vq[$];
    int         fq[$];
    @(negedge clk);
    dc = BUS_COMMAND'($urandom_range(0, 2));
    ic = BUS_COMMAND'($urandom_range(0, 2));
    rst = 1'b0;
    d_command = dc; d_addr = XW'($urandom); d_data = {$urandom, $urandom};
    i_command = ic; i_addr = XW'($urandom);
    mem_rdata = {$urandom, $urandom};
    for (int t = 1; t < NT; t++) if (m_valid[t]) vq.push_back(t);
    mt = 4'd0;
    r  = int'($urandom_range(0, 99));
    if (r < 40 && vq.size() > 0) mt = 4'(vq[$urandom_range(0, vq.size() - 1)]);
    else if (r < 43)             mt = 4'($urandom_range(1, NT - 1));
    g  = grantOf();
    mr = 4'd0;
    if (g != 0 && $urandom_range(0, 99) < 65) begin
      for (int t = 1; t < NT; t++) if (!m_valid[t] || t == int'(mt)) fq.push_back(t);
      if (fq.size() > 0) mr = 4'(fq[$urandom_range(0, fq.size() - 1)]);
    end
    mem_tag = mt;
    mem_response = mr;
    #1;
    checkOutput();
    finishCycle();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit expD;
    rst = 1'b1;
    d_command = BUS_NONE; i_command = BUS_NONE;
    d_addr = '0; d_data = '0; i_addr = '0;
    mem_response = 4'd0; mem_tag = 4'd0; mem_rdata = '0;
    modelReset();

    // Reset holds outputs quiet even with requests and responses present
    applyStimulus(1'b1, BUS_LOAD, XW'(32'h40), 64'h1, BUS_LOAD, XW'(32'h80), 4'd2, 4'd3, 64'h9);
    cmpVal("rst_mem_command", 64'(mem_command), 64'(BUS_NONE));
    cmpVal("rst_d_response", 64'(d_response), 64'd0);
    cmpVal("rst_i_response", 64'(i_response), 64'd0);
    cmpVal("rst_d_ret_tag", 64'(d_ret_tag), 64'd0);
    cmpVal("rst_tag_err", 64'(tag_err), 64'd0);
    finishCycle();

    // Single D load and its return
    doReset();
    applyStimulus(1'b0, BUS_LOAD, XW'(32'h100), 64'h0, BUS_NONE, '0, 4'd3, 4'd0, '0);
    cmpVal("load_d_response", 64'(d_response), 64'd3);
    cmpVal("load_mem_addr", 64'(mem_addr), 64'h100);
    cmpVal("load_i_response", 64'(i_response), 64'd0);
    finishCycle();
    idle(4'd0, '0);
    cmpVal("load_d_outstanding", 64'(d_outstanding), 64'd1);
    finishCycle();
    idle(4'd3, 64'hDEAD);
    cmpVal("ret_d_ret_tag", 64'(d_ret_tag), 64'd3);
    cmpVal("ret_ret_data", 64'(ret_data), 64'hDEAD);
    cmpVal("ret_i_ret_tag", 64'(i_ret_tag), 64'd0);
    finishCycle();
    idle(4'd0, '0);
    cmpVal("ret_d_outstanding", 64'(d_outstanding), 64'd0);
    finishCycle();

    // Both request every cycle, all accepted with tags 1..4
    doReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, BUS_LOAD, XW'(32'h1000 + k), 64'(k), BUS_LOAD, XW'(32'h2000 + k),
                    4'(k + 1), 4'd0, '0);
      expD = !(RR && (k % 2 == 1));
      cmpVal($sformatf("both_d_response_%0d", k), 64'(d_response), expD ? 64'(k + 1) : 64'd0);
      cmpVal($sformatf("both_i_response_%0d", k), 64'(i_response), expD ? 64'd0 : 64'(k + 1));
      finishCycle();
    end

    // I locked through a 3-cycle stall while D becomes active
    doReset();
    applyStimulus(1'b0, BUS_NONE, '0, '0, BUS_LOAD, XW'(32'h300), 4'd0, 4'd0, '0);
    cmpVal("lock_c1_mem_addr", 64'(mem_addr), 64'h300);
    finishCycle();
    for (int k = 2; k <= 3; k++) begin
      applyStimulus(1'b0, BUS_LOAD, XW'(32'h400), '0, BUS_LOAD, XW'(32'h300), 4'd0, 4'd0, '0);
      cmpVal($sformatf("lock_c%0d_mem_addr", k), 64'(mem_addr), 64'h300);
      finishCycle();
    end
    applyStimulus(1'b0, BUS_LOAD, XW'(32'h400), '0, BUS_LOAD, XW'(32'h300), 4'd6, 4'd0, '0);
    cmpVal("lock_c4_i_response", 64'(i_response), 64'd6);
    cmpVal("lock_c4_d_response", 64'(d_response), 64'd0);
    finishCycle();
    applyStimulus(1'b0, BUS_LOAD, XW'(32'h400), '0, BUS_LOAD, XW'(32'h300), 4'd7, 4'd0, '0);
    cmpVal("lock_c5_d_response", 64'(d_response), 64'd7);
    cmpVal("lock_c5_mem_addr", 64'(mem_addr), 64'h400);
    finishCycle();

    // Store creates no entry; its tag returning is an error
    doReset();
    applyStimulus(1'b0, BUS_STORE, XW'(32'h200), 64'h55, BUS_NONE, '0, 4'd5, 4'd0, '0);
    cmpVal("store_mem_command", 64'(mem_command), 64'(BUS_STORE));
    cmpVal("store_mem_data", 64'(mem_data), 64'h55);
    cmpVal("store_d_response", 64'(d_response), 64'd5);
    finishCycle();
    idle(4'd0, '0);
    cmpVal("store_d_outstanding", 64'(d_outstanding), 64'd0);
    finishCycle();
    idle(4'd5, 64'h1234);
    cmpVal("store_ret_d", 64'(d_ret_tag), 64'd0);
    cmpVal("store_ret_i", 64'(i_ret_tag), 64'd0);
    finishCycle();
    idle(4'd0, '0);
    cmpVal("store_tag_err", 64'(tag_err), 64'd1);
    finishCycle();

    // Tag 7 returns to I while being re-accepted for D
    doReset();
    applyStimulus(1'b0, BUS_NONE, '0, '0, BUS_LOAD, XW'(32'h700), 4'd7, 4'd0, '0);
    cmpVal("reuse_i_response", 64'(i_response), 64'd7);
    finishCycle();
    applyStimulus(1'b0, BUS_LOAD, XW'(32'h710), '0, BUS_NONE, '0, 4'd7, 4'd7, 64'h77);
    cmpVal("reuse_i_ret_tag", 64'(i_ret_tag), 64'd7);
    cmpVal("reuse_d_response", 64'(d_response), 64'd7);
    finishCycle();
    idle(4'd0, '0);
    cmpVal("reuse_d_outstanding", 64'(d_outstanding), 64'd1);
    cmpVal("reuse_i_outstanding", 64'(i_outstanding), 64'd0);
    finishCycle();
    idle(4'd7, 64'h78);
    cmpVal("reuse_d_ret_tag", 64'(d_ret_tag), 64'd7);
    finishCycle();

    // Reset mid-flight drops ownership
    doReset();
    applyStimulus(1'b0, BUS_LOAD, XW'(32'h800), '0, BUS_NONE, '0, 4'd1, 4'd0, '0);
    finishCycle();
    applyStimulus(1'b0, BUS_NONE, '0, '0, BUS_LOAD, XW'(32'h900), 4'd2, 4'd0, '0);
    finishCycle();
    idle(4'd0, '0);
    cmpVal("mid_d_outstanding", 64'(d_outstanding), 64'd1);
    cmpVal("mid_i_outstanding", 64'(i_outstanding), 64'd1);
    finishCycle();
    applyStimulus(1'b1, BUS_LOAD, XW'(32'h810), '0, BUS_NONE, '0, 4'd3, 4'd0, '0);
    cmpVal("mid_rst_d_outstanding", 64'(d_outstanding), 64'd0);
    cmpVal("mid_rst_i_outstanding", 64'(i_outstanding), 64'd0);
    cmpVal("mid_rst_mem_command", 64'(mem_command), 64'(BUS_NONE));
    finishCycle();
    idle(4'd1, 64'hAB);
    cmpVal("mid_old_d_ret_tag", 64'(d_ret_tag), 64'd0);
    finishCycle();
    idle(4'd0, '0);
    cmpVal("mid_old_tag_err", 64'(tag_err), 64'd1);
    finishCycle();

    // Randomized traffic with occasional resets
    doReset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) doReset();
      else                             randomCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
